// File: rtl/capture_sequencer.sv
// Stereo capture sequencer: shared camera trigger, dual frame-done wait with
// tick-based timeout, fixed trigger pacing, frame/timeout counters.
module capture_sequencer #(
  parameter int TRIG_TICKS    = 4,
  parameter int TIMEOUT_TICKS = 1000,
  parameter int PERIOD_TICKS  = 33
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        tick_in,
  input  logic        enable_in,
  input  logic        done_a_in,
  input  logic        done_b_in,
  output logic        trig_out,
  output logic        busy_out,
  output logic        frame_valid_out,
  output logic        timeout_out,
  output logic [15:0] frame_cnt_out,
  output logic [7:0]  err_cnt_out
);
  localparam int MAX_TICKS = (TIMEOUT_TICKS > PERIOD_TICKS) ? TIMEOUT_TICKS : PERIOD_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);
  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_TICKS - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_TICKS - 1);
  localparam logic [TW-1:0] PERIOD    = TW'(PERIOD_TICKS);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT, HOLDOFF} state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_inc;
  logic          fa, fb;

  // Tick counter saturates so a stalled holdoff can never wrap back below PERIOD.
  assign tcnt_inc = (tick_in && (tcnt != '1)) ? tcnt + TW'(1) : tcnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      tcnt            <= '0;
      fa              <= 1'b0;
      fb              <= 1'b0;
      trig_out        <= 1'b0;
      busy_out        <= 1'b0;
      frame_valid_out <= 1'b0;
      timeout_out     <= 1'b0;
      frame_cnt_out   <= '0;
      err_cnt_out     <= '0;
    end else begin
      frame_valid_out <= 1'b0;
      timeout_out     <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_in && tick_in) begin
            state    <= TRIG;
            tcnt     <= '0;
            fa       <= 1'b0;
            fb       <= 1'b0;
            trig_out <= 1'b1;
            busy_out <= 1'b1;
          end
        end
        TRIG: begin
          tcnt <= tcnt_inc;
          if (done_a_in) fa <= 1'b1;
          if (done_b_in) fb <= 1'b1;
          if (tick_in && (tcnt == TRIG_LAST)) begin
            state    <= WAIT;
            trig_out <= 1'b0;
          end
        end
        WAIT: begin
          tcnt <= tcnt_inc;
          if (done_a_in) fa <= 1'b1;
          if (done_b_in) fb <= 1'b1;
          // Success is checked first so a done landing on the timeout tick still counts.
          if ((fa | done_a_in) & (fb | done_b_in)) begin
            state           <= HOLDOFF;
            frame_valid_out <= 1'b1;
            frame_cnt_out   <= frame_cnt_out + 16'd1;
          end else if (tick_in && (tcnt == TO_LAST)) begin
            state       <= HOLDOFF;
            timeout_out <= 1'b1;
            if (err_cnt_out != 8'hFF) err_cnt_out <= err_cnt_out + 8'd1;
          end
        end
        HOLDOFF: begin
          if (tcnt >= PERIOD) begin
            if (enable_in) begin
              state    <= TRIG;
              tcnt     <= '0;
              fa       <= 1'b0;
              fb       <= 1'b0;
              trig_out <= 1'b1;
            end else begin
              state    <= IDLE;
              busy_out <= 1'b0;
            end
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: stimulus tables replayed cycle by cycle and
// compared against an event-level model of the capture timeline.
module tb_capture_sequencer;
  localparam int TT   = 2;
  localparam int TO   = 5;
  localparam int PT   = 8;
  localparam int MAXC = 8600;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        tick_in = 1'b0;
  logic        enable_in = 1'b0;
  logic        done_a_in = 1'b0;
  logic        done_b_in = 1'b0;
  logic        trig_out, busy_out, frame_valid_out, timeout_out;
  logic [15:0] frame_cnt_out;
  logic [7:0]  err_cnt_out;

  int tests = 0;
  int fails = 0;

  bit          st_en[MAXC], st_tk[MAXC], st_da[MAXC], st_db[MAXC];
  bit          e_trig[MAXC], e_busy[MAXC], e_fv[MAXC], e_to[MAXC];
  logic [27:0] obs[MAXC], expv[MAXC];

  capture_sequencer #(.TRIG_TICKS(TT), .TIMEOUT_TICKS(TO), .PERIOD_TICKS(PT)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .tick_in(tick_in), .enable_in(enable_in),
    .done_a_in(done_a_in), .done_b_in(done_b_in), .trig_out(trig_out), .busy_out(busy_out),
    .frame_valid_out(frame_valid_out), .timeout_out(timeout_out),
    .frame_cnt_out(frame_cnt_out), .err_cnt_out(err_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  // Packed observation word: {trig, busy, frame_valid, timeout, frame_cnt, err_cnt}
  function automatic logic [27:0] outs();
    return {trig_out, busy_out, frame_valid_out, timeout_out, frame_cnt_out, err_cnt_out};
  endfunction

  task automatic do_reset();
    rst_n_in = 1'b0; tick_in = 1'b0; done_a_in = 1'b0; done_b_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
  endtask

  task automatic stim_default(input int n);
    for (int j = 0; j < n; j++) begin
      st_en[j] = 1'b1; st_tk[j] = (j % 4 == 3); st_da[j] = 1'b0; st_db[j] = 1'b0;
    end
  endtask

  // Entry j holds the inputs sampled at edge j; obs[j] the outputs just after it.
  task automatic run(input int n);
    for (int j = 0; j < n; j++) begin
      enable_in = st_en[j]; tick_in = st_tk[j]; done_a_in = st_da[j]; done_b_in = st_db[j];
      @(posedge clk_in); #1;
      obs[j] = outs();
    end
    tick_in = 1'b0; done_a_in = 1'b0; done_b_in = 1'b0;
  endtask

  // Timeline model: a capture starts at edge s, the trigger spans the first TT
  // ticks after s, it ends at the earlier of "both dones seen while armed" and
  // the TO-th tick, and the next start waits for the PT-th tick plus one cycle.
  task automatic model(input int n, input logic [15:0] fc0);
    int k, s, cnt, tt, tmo, tp, ca, cb, se, e, h;
    logic [15:0] fc;
    logic [7:0]  ec;
    for (int j = 0; j < n; j++) begin
      e_trig[j] = 0; e_busy[j] = 0; e_fv[j] = 0; e_to[j] = 0;
    end
    k = 0; s = -1;
    while (k < n) begin
      if (s < 0) begin
        if (st_en[k] && st_tk[k]) s = k;
        else begin k++; continue; end
      end
      cnt = 0; tt = n; tmo = n; tp = n;
      for (int j = s + 1; j < n; j++) if (st_tk[j]) begin
        cnt++;
        if (cnt == TT) tt = j;
        if (cnt == TO) tmo = j;
        if (cnt == PT) tp = j;
      end
      ca = n; cb = n;
      for (int j = n - 1; j > s; j--) begin
        if (st_da[j]) ca = j;
        if (st_db[j]) cb = j;
      end
      se = (ca > cb) ? ca : cb;
      if (se < tt + 1) se = tt + 1;
      for (int j = s; j < n && j < tt; j++) e_trig[j] = 1;
      if (se <= tmo && se < n) begin e = se; e_fv[e] = 1; end
      else if (tmo < n) begin e = tmo; e_to[e] = 1; end
      else begin
        for (int j = s; j < n; j++) e_busy[j] = 1;
        break;
      end
      h = (tp + 1 > e + 1) ? tp + 1 : e + 1;
      for (int j = s; j < n && j < h; j++) e_busy[j] = 1;
      if (h >= n) break;
      if (st_en[h]) begin s = h; k = h; end
      else begin s = -1; k = h + 1; end
    end
    fc = fc0; ec = 8'd0;
    for (int j = 0; j < n; j++) begin
      if (e_fv[j]) fc = fc + 16'd1;
      if (e_to[j] && ec != 8'hFF) ec = ec + 8'd1;
      expv[j] = {e_trig[j], e_busy[j], e_fv[j], e_to[j], fc, ec};
    end
  endtask

  task automatic test_reset();
    int bad;
    enable_in = 1'b1; tick_in = 1'b0; rst_n_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in); #1;
      tests++;
      if (outs() !== 28'h0) begin
        fails++; $display("FAIL reset_state cycle %0d got %h exp %h", i, outs(), 28'h0);
      end
    end
    rst_n_in = 1'b1;
    stim_default(40); run(40); model(40, 16'h0);
    bad = -1;
    for (int j = 0; j < 40; j++) if (obs[j] !== expv[j]) begin bad = j; break; end
    tests++;
    if (bad >= 0) begin fails++; $display("FAIL reset_wave cycle %0d got %h exp %h", bad, obs[bad], expv[bad]); end
    tests++;
    if ({obs[2][27], obs[3][27], obs[3][26]} !== 3'b011) begin
      fails++; $display("FAIL trig_rise got %b exp 011", {obs[2][27], obs[3][27], obs[3][26]});
    end
    tests++;
    if ({obs[10][27], obs[11][27]} !== 2'b10) begin
      fails++; $display("FAIL trig_width got %b exp 10", {obs[10][27], obs[11][27]});
    end
  endtask

  task automatic test_normal();
    int bad;
    do_reset(); stim_default(80); st_da[15] = 1; st_db[17] = 1;
    run(80); model(80, 16'h0);
    bad = -1;
    for (int j = 0; j < 80; j++) if (obs[j] !== expv[j]) begin bad = j; break; end
    tests++;
    if (bad >= 0) begin fails++; $display("FAIL normal_wave cycle %0d got %h exp %h", bad, obs[bad], expv[bad]); end
    tests++;
    if ({obs[16][25], obs[17][25], obs[18][25], obs[17][23:8]} !== {3'b010, 16'd1}) begin
      fails++; $display("FAIL normal_frame got fv=%b%b%b cnt=%0d exp fv=010 cnt=1",
                        obs[16][25], obs[17][25], obs[18][25], obs[17][23:8]);
    end
    tests++;
    if ({obs[35][27], obs[36][27]} !== 2'b01) begin
      fails++; $display("FAIL normal_period got %b exp 01", {obs[35][27], obs[36][27]});
    end
  endtask

  task automatic test_timeout();
    int bad;
    do_reset(); stim_default(60); st_da[15] = 1;
    run(60); model(60, 16'h0);
    bad = -1;
    for (int j = 0; j < 60; j++) if (obs[j] !== expv[j]) begin bad = j; break; end
    tests++;
    if (bad >= 0) begin fails++; $display("FAIL timeout_wave cycle %0d got %h exp %h", bad, obs[bad], expv[bad]); end
    tests++;
    if ({obs[23][25:24], obs[23][23:8], obs[23][7:0]} !== {2'b01, 16'd0, 8'd1}) begin
      fails++; $display("FAIL timeout_pulse got %h exp fv/to=01 cnt=0 err=1", obs[23]);
    end
  endtask

  task automatic test_collision();
    int bad;
    do_reset(); stim_default(60); st_da[15] = 1; st_db[23] = 1;
    run(60); model(60, 16'h0);
    bad = -1;
    for (int j = 0; j < 60; j++) if (obs[j] !== expv[j]) begin bad = j; break; end
    tests++;
    if (bad >= 0) begin fails++; $display("FAIL collision_wave cycle %0d got %h exp %h", bad, obs[bad], expv[bad]); end
    tests++;
    if ({obs[23][25:24], obs[23][23:8], obs[23][7:0]} !== {2'b10, 16'd1, 8'd0}) begin
      fails++; $display("FAIL collision_pulse got %h exp fv/to=10 cnt=1 err=0", obs[23]);
    end
  endtask

  task automatic test_enable_drop();
    int bad;
    do_reset(); stim_default(60);
    for (int j = 8; j < 60; j++) st_en[j] = 1'b0;
    st_da[15] = 1; st_db[17] = 1;
    run(60); model(60, 16'h0);
    bad = -1;
    for (int j = 0; j < 60; j++) if (obs[j] !== expv[j]) begin bad = j; break; end
    tests++;
    if (bad >= 0) begin fails++; $display("FAIL enable_drop_wave cycle %0d got %h exp %h", bad, obs[bad], expv[bad]); end
    tests++;
    if ({obs[17][25], obs[35][26], obs[36][26], obs[59][27:26]} !== 5'b11000) begin
      fails++; $display("FAIL enable_drop_idle got %b exp 11000",
                        {obs[17][25], obs[35][26], obs[36][26], obs[59][27:26]});
    end
  endtask

  task automatic test_async_reset();
    do_reset(); stim_default(40); st_da[15] = 1; st_db[17] = 1;
    run(40);
    tests++;
    if ({trig_out, frame_cnt_out} !== {1'b1, 16'd1}) begin
      fails++; $display("FAIL async_pre got trig=%b cnt=%0d exp trig=1 cnt=1", trig_out, frame_cnt_out);
    end
    #3 rst_n_in = 1'b0;
    #1;
    tests++;
    if (outs() !== 28'h0) begin
      fails++; $display("FAIL async_reset got %h exp %h", outs(), 28'h0);
    end
    @(posedge clk_in); #1 rst_n_in = 1'b1;
  endtask

  task automatic test_random();
    int bad;
    bit en;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      en = 1'b1;
      for (int j = 0; j < 300; j++) begin
        if ($urandom_range(0, 39) == 0) en = ~en;
        st_en[j] = en;
        st_tk[j] = ($urandom_range(0, 2) == 0);
        st_da[j] = ($urandom_range(0, 7) == 0);
        st_db[j] = ($urandom_range(0, 7) == 0);
      end
      run(300); model(300, 16'h0);
      bad = -1;
      for (int j = 0; j < 300; j++) if (obs[j] !== expv[j]) begin bad = j; break; end
      tests++;
      if (bad >= 0) begin
        fails++; $display("FAIL random_wave iter %0d cycle %0d got %h exp %h", it, bad, obs[bad], expv[bad]);
      end
    end
  endtask

  task automatic test_err_saturation();
    int bad;
    do_reset(); stim_default(8500);
    run(8500); model(8500, 16'h0);
    bad = -1;
    for (int j = 0; j < 8500; j++) if (obs[j] !== expv[j]) begin bad = j; break; end
    tests++;
    if (bad >= 0) begin fails++; $display("FAIL err_sat_wave cycle %0d got %h exp %h", bad, obs[bad], expv[bad]); end
    tests++;
    if (err_cnt_out !== 8'hFF) begin
      fails++; $display("FAIL err_saturate got %0d exp 255", err_cnt_out);
    end
  endtask

  task automatic test_frame_wrap();
    int bad;
    bit seen_max, wrapped;
    do_reset();
    force dut.frame_cnt_out = 16'hFFFE;
    #1 release dut.frame_cnt_out;
    stim_default(140);
    for (int j = 0; j < 140; j++) if (j % 4 == 1) begin st_da[j] = 1; st_db[j] = 1; end
    run(140); model(140, 16'hFFFE);
    bad = -1;
    for (int j = 0; j < 140; j++) if (obs[j] !== expv[j]) begin bad = j; break; end
    tests++;
    if (bad >= 0) begin fails++; $display("FAIL wrap_wave cycle %0d got %h exp %h", bad, obs[bad], expv[bad]); end
    seen_max = 0; wrapped = 0;
    for (int j = 0; j < 140; j++) begin
      if (obs[j][23:8] === 16'hFFFF) seen_max = 1;
      else if (seen_max && obs[j][23:8] === 16'h0000) wrapped = 1;
    end
    tests++;
    if (wrapped !== 1'b1) begin
      fails++; $display("FAIL frame_wrap got wrapped=%b final=%h exp wrapped=1", wrapped, frame_cnt_out);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_collision();
    test_enable_drop();
    test_async_reset();
    test_random();
    test_err_saturation();
    test_frame_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
